// File: rtl/ahfp_add_arbiter.sv
// -----------------------------------------------------------------------------
// ahfp_add_arbiter
//
// Shares one pipelined single-precision adder (ahfp_add_multi, fixed latency,
// no stall, no reset) between N_REQ requesters. Each cycle at most one
// requester is granted. Its operand pair is registered into the adder, and its
// index travels down a tag pipeline matched to the adder latency. When the
// aligned tag is valid, the returning sum is registered and steered to the
// originator as a one-cycle, one-hot response. Each requester may have at most
// MAX_OUT operations in flight.
//
// Configuration macro:
//   AHFP_ARB_RR_EN  defined   -> round-robin arbitration with a priority
//                                pointer (reset 0, moves past each winner).
//                   undefined -> fixed priority, lowest eligible index wins.
//
// Parameters:
//   N_REQ        number of requesters (2..8)
//   ADD_LATENCY  clock edges from operand capture to adder result update
//   MAX_OUT      maximum in-flight operations per requester (1..15)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   req_valid    per-requester operation request
//   req_dataa    operand A, requester i on bits [32i+31:32i]
//   req_datab    operand B, packed the same way
//   req_ready    grant, combinational, one-hot or zero
//   add_dataa    registered operand A to the adder
//   add_datab    registered operand B to the adder
//   add_result   adder result
//   resp_valid   registered one-hot response strobe, one cycle per operation
//   resp_result  registered sum, meaningful while any resp_valid bit is high
//   busy         high while any operation is in flight
//
// Handshake: a transfer from requester i happens on a rising edge where
// req_valid[i] & req_ready[i]. req_ready never depends on anything other than
// req_valid and internal state, and responses carry no backpressure.
// -----------------------------------------------------------------------------
module ahfp_add_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ADD_LATENCY = 7,
    parameter int MAX_OUT     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_dataa,
    input  logic [32*N_REQ-1:0]  req_datab,
    output logic [N_REQ-1:0]     req_ready,
    output logic [31:0]          add_dataa,
    output logic [31:0]          add_datab,
    input  logic [31:0]          add_result,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [31:0]          resp_result,
    output logic                 busy
);

    localparam int         ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    // Per-requester in-flight counters.
    logic [3:0]       out_cnt [N_REQ];
    logic [N_REQ-1:0] eligible;

    // Arbitration result.
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;

    // Operand mux for the winner.
    logic [31:0] sel_dataa;
    logic [31:0] sel_datab;

    // Tag pipeline: stage s holds the tag of the operation issued s edges ago.
    // Stage ADD_LATENCY lines up with add_result.
    logic [ADD_LATENCY:0] tag_v;
    logic [ID_W-1:0]      tag_id [ADD_LATENCY+1];

    // One-hot response that loads on the coming edge.
    logic [N_REQ-1:0] resp_valid_next;

    // -------------------------------------------------------------------------
    // Eligibility
    // -------------------------------------------------------------------------
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && (out_cnt[i] < MAX_CNT);
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef AHFP_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr;

    // Search starts at rr_ptr and wraps from N_REQ-1 back to 0. The sum is one
    // bit wider than an index so the wrap can be done by a single subtract.
    always_comb begin
        logic [ID_W:0]   pos;
        logic [ID_W-1:0] idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (pos >= (ID_W+1)'(N_REQ)) begin
                pos = pos - (ID_W+1)'(N_REQ);
            end
            idx = pos[ID_W-1:0];
            if (!grant_any && eligible[idx]) begin
                grant_any     = 1'b1;
                grant[idx]    = 1'b1;
                grant_id      = idx;
            end
        end
    end

    // Pointer moves just past the winner on each transfer, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            if (grant_id == ID_W'(N_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id + ID_W'(1);
            end
        end
    end
`else
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_any && eligible[k]) begin
                grant_any = 1'b1;
                grant[k]  = 1'b1;
                grant_id  = ID_W'(k);
            end
        end
    end
`endif

    assign req_ready = grant;

    // -------------------------------------------------------------------------
    // Operand registers: load the winner's operands, hold otherwise.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_dataa = '0;
        sel_datab = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_dataa = req_dataa[32*i +: 32];
                sel_datab = req_datab[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_dataa <= '0;
            add_datab <= '0;
        end else if (grant_any) begin
            add_dataa <= sel_dataa;
            add_datab <= sel_datab;
        end
    end

    // -------------------------------------------------------------------------
    // Tag pipeline: shifts every edge. Reset clears all valids, which drops
    // every operation in flight; the adder keeps its stale contents but they
    // are never registered because no aligned tag is valid.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            for (int s = 0; s <= ADD_LATENCY; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[ADD_LATENCY-1:0], grant_any};
            tag_id[0] <= grant_id;
            for (int s = 1; s <= ADD_LATENCY; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response register
    // -------------------------------------------------------------------------
    always_comb begin
        resp_valid_next = '0;
        if (tag_v[ADD_LATENCY]) begin
            resp_valid_next[tag_id[ADD_LATENCY]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid  <= '0;
            resp_result <= '0;
        end else begin
            resp_valid <= resp_valid_next;
            if (tag_v[ADD_LATENCY]) begin
                resp_result <= add_result;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outstanding counters. The decrement uses the response that loads on this
    // same edge, so a capped requester is eligible again in the very cycle its
    // response is presented. Issue and response together leave it unchanged.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                out_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant[i] && !resp_valid_next[i]) begin
                    if (out_cnt[i] < MAX_CNT) begin
                        out_cnt[i] <= out_cnt[i] + 4'd1;
                    end
                end else if (!grant[i] && resp_valid_next[i]) begin
                    if (out_cnt[i] != 4'd0) begin
                        out_cnt[i] <= out_cnt[i] - 4'd1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Busy: anything in the tag pipeline or being presented as a response.
    // -------------------------------------------------------------------------
    assign busy = (|tag_v) || (|resp_valid);

endmodule
